// File: rtl/apb_master_mslave.sv
// APB requester: accepts valid/ready commands and runs them as APB transfers on one of
// 2**SEL_BITS slaves, with byte strobes, back-to-back issue and a wait-state timeout.
module apb_master_mslave #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 8,
  parameter int SEL_BITS   = 1,
  parameter int TIMEOUT    = 16
) (
  input  logic                               pclk,
  input  logic                               preset,
  input  logic                               cmd_valid,
  output logic                               cmd_ready,
  input  logic                               cmd_write,
  input  logic [ADDR_WIDTH-1:0]              cmd_addr,
  input  logic [DATA_WIDTH-1:0]              cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]            cmd_strb,
  output logic                               rsp_valid,
  output logic [DATA_WIDTH-1:0]              rsp_rdata,
  output logic                               rsp_err,
  output logic                               rsp_timeout,
  output logic [(2**SEL_BITS)-1:0]           psel,
  output logic                               penable,
  output logic                               pwrite,
  output logic [ADDR_WIDTH-1:0]              paddr,
  output logic [DATA_WIDTH-1:0]              pwdata,
  output logic [DATA_WIDTH/8-1:0]            pstrb,
  input  logic [(2**SEL_BITS)-1:0]           pready,
  input  logic [(2**SEL_BITS)-1:0]           pslverr,
  input  logic [(2**SEL_BITS)*DATA_WIDTH-1:0] prdata,
  output logic [1:0]                         dbg_state_o
);

  localparam int NS = 2**SEL_BITS;
  localparam int SW = DATA_WIDTH/8;
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [SEL_BITS-1:0]   sel_q, sel_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [SW-1:0]         pstrb_q, pstrb_d;
  logic [CW-1:0]         wait_q, wait_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_timeout_q, rsp_timeout_d;

  logic                  pready_sel;
  logic                  pslverr_sel;
  logic [DATA_WIDTH-1:0] prdata_sel;
  logic                  to_fire;
  logic                  done;
  logic                  accept;

  // Only the selected slave's response signals are ever looked at.
  always_comb begin
    pready_sel  = pready[sel_q];
    pslverr_sel = pslverr[sel_q];
    prdata_sel  = '0;
    for (int k = 0; k < NS; k++) begin
      if (sel_q == SEL_BITS'(k)) prdata_sel = prdata[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Fires on the TIMEOUT-th consecutive wait cycle of one ACCESS phase.
  assign to_fire = (TIMEOUT != 0) && (state_q == ACCESS) && !pready_sel &&
                   (wait_q == CW'(TIMEOUT - 1));
  assign done      = (state_q == ACCESS) && (pready_sel || to_fire);
  assign cmd_ready = !preset && ((state_q == IDLE) || done);
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    paddr_d       = paddr_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    wait_d        = wait_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;

    case (state_q)
      IDLE:    if (accept) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (done) state_d = accept ? SETUP : IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      sel_d    = cmd_addr[ADDR_WIDTH-1 -: SEL_BITS];
      paddr_d  = cmd_addr;
      pwrite_d = cmd_write;
      pwdata_d = cmd_wdata;
      pstrb_d  = cmd_strb & {SW{cmd_write}};
    end

    if ((TIMEOUT != 0) && (state_q == ACCESS) && !pready_sel && !to_fire) begin
      wait_d = wait_q + CW'(1);
    end
    if (state_d != ACCESS) wait_d = '0;

    if (done) begin
      rsp_valid_d   = 1'b1;
      rsp_timeout_d = !pready_sel;
      rsp_err_d     = pready_sel ? pslverr_sel : 1'b1;
      rsp_rdata_d   = (pready_sel && !pwrite_q) ? prdata_sel : '0;
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q       <= IDLE;
      sel_q         <= '0;
      paddr_q       <= '0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      wait_q        <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      paddr_q       <= paddr_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      wait_q        <= wait_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  always_comb begin
    psel = '0;
    for (int k = 0; k < NS; k++) begin
      psel[k] = (state_q != IDLE) && (sel_q == SEL_BITS'(k));
    end
  end

  assign penable     = (state_q == ACCESS);
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign pstrb       = pstrb_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_apb_master_mslave.sv
// Directed bench for apb_master_mslave: one instance with TIMEOUT=4 and one with the
// timeout disabled, both fed the same stimulus.
module tb_apb_master_mslave;

  logic        pclk = 1'b0;
  logic        preset;
  logic        cmd_valid;
  logic        cmd_write;
  logic [8:0]  cmd_addr;
  logic [7:0]  cmd_wdata;
  logic [0:0]  cmd_strb;
  logic [1:0]  pready;
  logic [1:0]  pslverr;
  logic [15:0] prdata;

  logic        cmd_ready, rsp_valid, rsp_err, rsp_timeout, penable, pwrite;
  logic [7:0]  rsp_rdata, pwdata;
  logic [1:0]  psel, dbg_state;
  logic [8:0]  paddr;
  logic [0:0]  pstrb;

  logic        nt_cmd_ready, nt_rsp_valid, nt_rsp_err, nt_rsp_timeout, nt_penable, nt_pwrite;
  logic [7:0]  nt_rsp_rdata, nt_pwdata;
  logic [1:0]  nt_psel, nt_dbg_state;
  logic [8:0]  nt_paddr;
  logic [0:0]  nt_pstrb;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 pclk = ~pclk;

  apb_master_mslave #(.ADDR_WIDTH(9), .DATA_WIDTH(8), .SEL_BITS(1), .TIMEOUT(4)) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pstrb(pstrb), .pready(pready), .pslverr(pslverr), .prdata(prdata),
    .dbg_state_o(dbg_state)
  );

  apb_master_mslave #(.ADDR_WIDTH(9), .DATA_WIDTH(8), .SEL_BITS(1), .TIMEOUT(0)) dut_nt (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(nt_cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(nt_rsp_valid), .rsp_rdata(nt_rsp_rdata), .rsp_err(nt_rsp_err),
    .rsp_timeout(nt_rsp_timeout),
    .psel(nt_psel), .penable(nt_penable), .pwrite(nt_pwrite), .paddr(nt_paddr),
    .pwdata(nt_pwdata), .pstrb(nt_pstrb), .pready(pready), .pslverr(pslverr),
    .prdata(prdata), .dbg_state_o(nt_dbg_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bus(input string tag, input logic [1:0] exp_psel, input logic exp_pen);
    chk({tag, ".psel"}, 32'(psel), 32'(exp_psel));
    chk({tag, ".penable"}, 32'(penable), 32'(exp_pen));
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic drive_cmd(input logic v, input logic w, input logic [8:0] a,
                           input logic [7:0] d, input logic s);
    cmd_valid = v;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_strb  = s;
  endtask

  initial begin
    preset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_strb = '0; pready = '0; pslverr = '0; prdata = '0;

    // reset
    step(); step(); #1;
    chk("rst.cmd_ready", 32'(cmd_ready), 0);
    chk_bus("rst", 2'b00, 1'b0);
    chk("rst.rsp_valid", 32'(rsp_valid), 0);
    chk("rst.paddr", 32'(paddr), 0);
    chk("rst.pstrb", 32'(pstrb), 0);
    chk("rst.state", 32'(dbg_state), 0);
    step(); preset = 1'b0; #1;
    chk("idle.cmd_ready", 32'(cmd_ready), 1);

    // zero-wait write to slave 0
    pready = 2'b11;
    drive_cmd(1'b1, 1'b1, 9'h005, 8'hA5, 1'b1); #1;
    chk("w0.accept", 32'(cmd_ready), 1);
    step(); cmd_valid = 1'b0; #1;
    chk_bus("w0.setup", 2'b01, 1'b0);
    chk("w0.paddr", 32'(paddr), 32'h005);
    chk("w0.pwdata", 32'(pwdata), 32'hA5);
    chk("w0.pstrb", 32'(pstrb), 1);
    chk("w0.pwrite", 32'(pwrite), 1);
    chk("w0.setup_ready", 32'(cmd_ready), 0);
    step(); #1;
    chk_bus("w0.access", 2'b01, 1'b1);
    chk("w0.access_ready", 32'(cmd_ready), 1);
    chk("w0.early_rsp", 32'(rsp_valid), 0);
    step(); #1;
    chk("w0.rsp_valid", 32'(rsp_valid), 1);
    chk("w0.rsp_err", 32'(rsp_err), 0);
    chk("w0.rsp_timeout", 32'(rsp_timeout), 0);
    chk_bus("w0.idle", 2'b00, 1'b0);
    chk("w0.paddr_hold", 32'(paddr), 32'h005);
    step(); #1;
    chk("w0.rsp_pulse", 32'(rsp_valid), 0);

    // read slave 1 with two wait states
    pready = 2'b01; prdata = 16'h0077;
    drive_cmd(1'b1, 1'b0, 9'h10A, 8'hFF, 1'b1); #1;
    chk("r1.accept", 32'(cmd_ready), 1);
    step(); cmd_valid = 1'b0; #1;
    chk_bus("r1.setup", 2'b10, 1'b0);
    chk("r1.pstrb", 32'(pstrb), 0);
    chk("r1.pwrite", 32'(pwrite), 0);
    chk("r1.paddr", 32'(paddr), 32'h10A);
    step(); #1;
    chk_bus("r1.wait1", 2'b10, 1'b1);
    chk("r1.wait1_ready", 32'(cmd_ready), 0);
    step(); #1;
    chk_bus("r1.wait2", 2'b10, 1'b1);
    chk("r1.wait2_ready", 32'(cmd_ready), 0);
    step(); pready = 2'b11; prdata = 16'h3C77; #1;
    chk_bus("r1.access3", 2'b10, 1'b1);
    chk("r1.done_ready", 32'(cmd_ready), 1);
    chk("r1.early_rsp", 32'(rsp_valid), 0);
    step(); #1;
    chk("r1.rsp_valid", 32'(rsp_valid), 1);
    chk("r1.rsp_rdata", 32'(rsp_rdata), 32'h3C);
    chk("r1.rsp_err", 32'(rsp_err), 0);
    chk_bus("r1.idle", 2'b00, 1'b0);

    // back-to-back: write slave 0 then read slave 1
    prdata = 16'h5A00;
    drive_cmd(1'b1, 1'b1, 9'h003, 8'h11, 1'b1); #1;
    chk("b2b.accept1", 32'(cmd_ready), 1);
    step(); drive_cmd(1'b1, 1'b0, 9'h1F0, 8'h22, 1'b1); #1;
    chk_bus("b2b.setup1", 2'b01, 1'b0);
    chk("b2b.setup1_ready", 32'(cmd_ready), 0);
    chk("b2b.paddr1", 32'(paddr), 32'h003);
    step(); #1;
    chk_bus("b2b.access1", 2'b01, 1'b1);
    chk("b2b.accept2", 32'(cmd_ready), 1);
    chk("b2b.pwdata1", 32'(pwdata), 32'h11);
    step(); cmd_valid = 1'b0; #1;
    chk_bus("b2b.setup2", 2'b10, 1'b0);
    chk("b2b.setup2_state", 32'(dbg_state), 1);
    chk("b2b.paddr2", 32'(paddr), 32'h1F0);
    chk("b2b.pstrb2", 32'(pstrb), 0);
    chk("b2b.rsp1_valid", 32'(rsp_valid), 1);
    chk("b2b.rsp1_rdata", 32'(rsp_rdata), 0);
    step(); #1;
    chk_bus("b2b.access2", 2'b10, 1'b1);
    chk("b2b.rsp_gap", 32'(rsp_valid), 0);
    step(); #1;
    chk("b2b.rsp2_valid", 32'(rsp_valid), 1);
    chk("b2b.rsp2_rdata", 32'(rsp_rdata), 32'h5A);
    chk_bus("b2b.idle", 2'b00, 1'b0);

    // pslverr on a wait cycle is ignored; other slave's pready/pslverr ignored
    pready = 2'b00; pslverr = 2'b01;
    drive_cmd(1'b1, 1'b1, 9'h020, 8'h42, 1'b1); #1;
    chk("se.accept", 32'(cmd_ready), 1);
    step(); cmd_valid = 1'b0; #1;
    chk_bus("se.setup", 2'b01, 1'b0);
    step(); pready = 2'b10; #1;
    chk_bus("se.wait", 2'b01, 1'b1);
    chk("se.iso_ready", 32'(cmd_ready), 0);
    step(); pready = 2'b01; pslverr = 2'b10; #1;
    chk("se.done_ready", 32'(cmd_ready), 1);
    step(); #1;
    chk("se.rsp_valid", 32'(rsp_valid), 1);
    chk("se.rsp_err0", 32'(rsp_err), 0);
    chk("se.rsp_timeout0", 32'(rsp_timeout), 0);
    // error returned on completion of a read
    pready = 2'b01; pslverr = 2'b01; prdata = 16'h009E;
    drive_cmd(1'b1, 1'b0, 9'h044, 8'h00, 1'b0); #1;
    step(); cmd_valid = 1'b0; #1;
    chk_bus("se2.setup", 2'b01, 1'b0);
    step(); #1;
    chk_bus("se2.access", 2'b01, 1'b1);
    step(); #1;
    chk("se2.rsp_valid", 32'(rsp_valid), 1);
    chk("se2.rsp_err", 32'(rsp_err), 1);
    chk("se2.rsp_timeout", 32'(rsp_timeout), 0);
    chk("se2.rsp_rdata", 32'(rsp_rdata), 32'h9E);

    // timeout after 4 wait cycles; the TIMEOUT=0 instance keeps waiting
    pready = 2'b00; pslverr = 2'b00; prdata = 16'h00AB;
    drive_cmd(1'b1, 1'b0, 9'h0F0, 8'h66, 1'b0); #1;
    chk("to.accept", 32'(cmd_ready), 1);
    step(); cmd_valid = 1'b0; #1;
    chk_bus("to.setup", 2'b01, 1'b0);
    chk("to.nt_psel", 32'(nt_psel), 32'b01);
    for (int i = 1; i <= 4; i++) begin
      step(); #1;
      chk_bus("to.access", 2'b01, 1'b1);
      chk("to.fire_ready", 32'(cmd_ready), 32'(i == 4));
      chk("to.nt_ready", 32'(nt_cmd_ready), 0);
    end
    step(); #1;
    chk_bus("to.abort", 2'b00, 1'b0);
    chk("to.rsp_valid", 32'(rsp_valid), 1);
    chk("to.rsp_err", 32'(rsp_err), 1);
    chk("to.rsp_timeout", 32'(rsp_timeout), 1);
    chk("to.rsp_rdata", 32'(rsp_rdata), 0);
    chk("to.nt_psel_held", 32'(nt_psel), 32'b01);
    chk("to.nt_penable", 32'(nt_penable), 1);
    chk("to.nt_rsp_valid", 32'(nt_rsp_valid), 0);
    step(); #1;
    chk("to.rsp_pulse", 32'(rsp_valid), 0);
    chk("to.rsp_timeout_hold", 32'(rsp_timeout), 1);
    for (int i = 0; i < 4; i++) begin
      step(); #1;
      chk("nt.penable", 32'(nt_penable), 1);
      chk("nt.no_rsp", 32'(nt_rsp_valid), 0);
      chk("to.state_idle", 32'(dbg_state), 0);
    end
    chk("nt.paddr", 32'(nt_paddr), 32'h0F0);
    chk("nt.pstrb", 32'(nt_pstrb), 0);
    chk("nt.pwrite", 32'(nt_pwrite), 0);
    chk("nt.pwdata", 32'(nt_pwdata), 32'h66);
    pready = 2'b01; #1;
    chk("nt.done_ready", 32'(nt_cmd_ready), 1);
    step(); #1;
    chk("nt.rsp_valid", 32'(nt_rsp_valid), 1);
    chk("nt.rsp_rdata", 32'(nt_rsp_rdata), 32'hAB);
    chk("nt.rsp_err", 32'(nt_rsp_err), 0);
    chk("nt.rsp_timeout", 32'(nt_rsp_timeout), 0);
    chk("nt.psel_idle", 32'(nt_psel), 0);
    chk("nt.state", 32'(nt_dbg_state), 0);
    chk("to.no_extra_rsp", 32'(rsp_valid), 0);

    // reset in the second ACCESS cycle
    pready = 2'b00;
    drive_cmd(1'b1, 1'b1, 9'h150, 8'hC3, 1'b1); #1;
    step(); cmd_valid = 1'b0; #1;
    chk_bus("mr.setup", 2'b10, 1'b0);
    step(); #1;
    chk_bus("mr.access1", 2'b10, 1'b1);
    step(); preset = 1'b1; pready = 2'b10; #1;
    chk_bus("mr.access2", 2'b10, 1'b1);
    chk("mr.ready_in_reset", 32'(cmd_ready), 0);
    step(); preset = 1'b0; pready = 2'b11; #1;
    chk_bus("mr.after", 2'b00, 1'b0);
    chk("mr.rsp_valid", 32'(rsp_valid), 0);
    chk("mr.rsp_err", 32'(rsp_err), 0);
    chk("mr.rsp_timeout", 32'(rsp_timeout), 0);
    chk("mr.rsp_rdata", 32'(rsp_rdata), 0);
    chk("mr.paddr", 32'(paddr), 0);
    chk("mr.pwdata", 32'(pwdata), 0);
    chk("mr.pstrb", 32'(pstrb), 0);
    chk("mr.pwrite", 32'(pwrite), 0);
    chk("mr.state", 32'(dbg_state), 0);
    chk("mr.cmd_ready", 32'(cmd_ready), 1);
    drive_cmd(1'b1, 1'b1, 9'h007, 8'h3F, 1'b1); #1;
    step(); cmd_valid = 1'b0; #1;
    chk_bus("mr.w_setup", 2'b01, 1'b0);
    chk("mr.w_pwdata", 32'(pwdata), 32'h3F);
    chk("mr.no_stale_rsp", 32'(rsp_valid), 0);
    step(); #1;
    chk_bus("mr.w_access", 2'b01, 1'b1);
    step(); #1;
    chk("mr.w_rsp_valid", 32'(rsp_valid), 1);
    chk("mr.w_rsp_err", 32'(rsp_err), 0);
    chk("mr.w_rsp_timeout", 32'(rsp_timeout), 0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
